// File: rtl/gate_sweep_pkg.sv
// Shared types and truth-table constants for the gate sweep sequencer.
package gate_sweep_pkg;

    // Sequencer states, kept as an enum for readability in waveforms and benches
    typedef enum logic [2:0] {
        GS_IDLE   = 3'd0,
        GS_DRIVE  = 3'd1,
        GS_SETTLE = 3'd2,
        GS_SAMPLE = 3'd3,
        GS_DONE   = 3'd4
    } gs_state_e;

    // Plain encodings used by the controller state register
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Two-input truth tables, bit i = output for input value i ({a,b} = i)
    localparam logic [3:0] NOR2_TT = 4'b0001;
    localparam logic [3:0] AND2_TT = 4'b1000;
    localparam logic [3:0] OR2_TT  = 4'b1110;

endpackage : gate_sweep_pkg

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweeper: drives every input vector to a small gate,
// waits a settle time, samples the output and accumulates mismatches.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned           N_IN       = 2,
    parameter int unsigned           SETTLE_CYC = 1,
    parameter logic [(2**N_IN)-1:0]  EXPECTED   = NOR2_TT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     gate_out,
    output logic [N_IN-1:0]          gate_in,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [N_IN:0]            err_count,
    output logic [(2**N_IN)-1:0]     fail_mask
);

    localparam int unsigned NVEC  = 2**N_IN;
    localparam int unsigned IDX_W = N_IN;
    localparam int unsigned ERR_W = N_IN + 1;
    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NVEC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);

    logic [2:0]        state_q,     state_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic [N_IN-1:0]   gate_in_q,   gate_in_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              pass_q,      pass_d;
    logic [ERR_W-1:0]  err_q,       err_d;
    logic [NVEC-1:0]   mask_q,      mask_d;
    logic              mismatch_c;

    // Gate output disagrees with the expected table entry for the current vector
    always_comb begin
        mismatch_c = (gate_out != EXPECTED[idx_q]);
    end

    // Next-state and next-output logic for the sweep sequencer
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gate_in_d = gate_in_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        mask_d    = mask_q;

        case (state_q)
            ST_IDLE: begin
                // Previous results stay visible until a new sweep is accepted
                if (start) begin
                    err_d     = '0;
                    mask_d    = '0;
                    pass_d    = 1'b0;
                    idx_d     = '0;
                    gate_in_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                cnt_d = SETTLE_LOAD;
                if (SETTLE_CYC != 0) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SETTLE: begin
                // Exit on the cycle the counter reads 1: SETTLE_CYC cycles here
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (mismatch_c) begin
                    err_d         = err_q + ERR_W'(1);
                    mask_d[idx_q] = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    // Verdict is taken from the count including this last sample
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    gate_in_d = N_IN'(idx_q + IDX_W'(1));
                    state_d   = ST_DRIVE;
                end
            end

            ST_DONE: begin
                // start is ignored here; a held start re-arms from IDLE
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            gate_in_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gate_in_q <= gate_in_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            mask_q    <= mask_d;
        end
    end

    assign gate_in   = gate_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule : gate_sweep_ctrl

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: table-driven sweeps against a NOR
// model with injectable stuck-at faults, plus reset/settle-time corner cases.
module tb_gate_sweep_ctrl;

    localparam int unsigned N_IN = 2;
    localparam int unsigned NVEC = 4;

    logic clk = 1'b0;
    logic rst;
    logic start, start0, start3;
    logic [1:0] fault;

    logic [N_IN-1:0] gin, gin0, gin3;
    logic            gout, gout0, gout3;
    logic            busy, busy0, busy3;
    logic            done, done0, done3;
    logic            pass, pass0, pass3;
    logic [N_IN:0]   errc, errc0, errc3;
    logic [NVEC-1:0] fmask, fmask0, fmask3;

    always #5 clk = ~clk;

    // Main instance: default settle time of 1
    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(1), .EXPECTED(4'b0001)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_out(gout),
        .gate_in(gin), .busy(busy), .done(done), .pass(pass),
        .err_count(errc), .fail_mask(fmask)
    );

    // Zero settle time build
    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(0), .EXPECTED(4'b0001)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .gate_out(gout0),
        .gate_in(gin0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(errc0), .fail_mask(fmask0)
    );

    // Three-cycle settle time build
    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(3), .EXPECTED(4'b0001)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .gate_out(gout3),
        .gate_in(gin3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(errc3), .fail_mask(fmask3)
    );

    function automatic logic nor_model(input logic [1:0] v);
        return ~(v[1] | v[0]);
    endfunction

    // Gate under control: 0 = healthy NOR, 1 = stuck at 0, 2 = stuck at 1
    always_comb begin
        case (fault)
            2'd0:    gout = nor_model(gin);
            2'd1:    gout = 1'b0;
            default: gout = 1'b1;
        endcase
    end
    assign gout0 = nor_model(gin0);
    assign gout3 = nor_model(gin3);

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;

    always @(negedge clk) if (done) done_pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]      fault;
        logic            extra_start;
        logic [N_IN:0]   err;
        logic [NVEC-1:0] mask;
        logic            pass;
    } vec_t;

    typedef struct {
        logic [N_IN:0]   err;
        logic [NVEC-1:0] mask;
        logic            pass;
        int              lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[5];

    // One full sweep on the main instance; expected result queued at start
    task automatic run_sweep(input vec_t v, input int id);
        int   k;
        bit   got;
        int   pulses_before;
        exp_t e;
        k = 0;
        got = 1'b0;
        @(negedge clk);
        fault = v.fault;
        start = 1'b1;
        sb_q.push_back('{err: v.err, mask: v.mask, pass: v.pass, lat: int'(NVEC * 3)});
        pulses_before = done_pulses;
        @(posedge clk);
        #1 start = 1'b0;
        while (!got && k < 64) begin
            @(negedge clk);
            if (k == 0) begin
                check($sformatf("busy_on_accept[%0d]", id), 32'(busy), 32'd1);
                check($sformatf("pass_cleared[%0d]", id), 32'(pass), 32'd0);
                check($sformatf("err_cleared[%0d]", id), 32'(errc), 32'd0);
            end
            if (k < int'(NVEC * 3))
                check($sformatf("gate_in[%0d] k=%0d", id, k), 32'(gin), 32'(k / 3));
            if (done) begin
                got = 1'b1;
                e = sb_q.pop_front();
                check($sformatf("latency[%0d]", id), 32'(k), 32'(e.lat));
                check($sformatf("err_count[%0d]", id), 32'(errc), 32'(e.err));
                check($sformatf("fail_mask[%0d]", id), 32'(fmask), 32'(e.mask));
                check($sformatf("pass[%0d]", id), 32'(pass), 32'(e.pass));
                check($sformatf("busy_in_done[%0d]", id), 32'(busy), 32'd1);
            end else begin
                if (v.extra_start && (k == 3 || k == 7)) start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                k++;
            end
        end
        check($sformatf("done_seen[%0d]", id), 32'(got), 32'd1);
        @(negedge clk);
        check($sformatf("done_width[%0d]", id), 32'(done), 32'd0);
        check($sformatf("busy_after[%0d]", id), 32'(busy), 32'd0);
        check($sformatf("err_held[%0d]", id), 32'(errc), 32'(v.err));
        check($sformatf("done_pulses[%0d]", id), 32'(done_pulses - pulses_before), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat0, lat3, k;

        vecs[0] = '{fault: 2'd0, extra_start: 1'b0, err: 3'd0, mask: 4'b0000, pass: 1'b1};
        vecs[1] = '{fault: 2'd1, extra_start: 1'b0, err: 3'd1, mask: 4'b0001, pass: 1'b0};
        vecs[2] = '{fault: 2'd2, extra_start: 1'b0, err: 3'd3, mask: 4'b1110, pass: 1'b0};
        vecs[3] = '{fault: 2'd0, extra_start: 1'b0, err: 3'd0, mask: 4'b0000, pass: 1'b1};
        vecs[4] = '{fault: 2'd0, extra_start: 1'b1, err: 3'd0, mask: 4'b0000, pass: 1'b1};

        rst = 1'b1;
        start = 1'b0;
        start0 = 1'b0;
        start3 = 1'b0;
        fault = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gate_in", 32'(gin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(errc), 32'd0);
        check("rst_mask", 32'(fmask), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_sweep(vecs[i], i);

        // Reset mid-sweep with a stuck-at-0 gate: one error already logged at cycle 5
        @(negedge clk);
        fault = 2'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_rst_err", 32'(errc), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_gate_in", 32'(gin), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(errc), 32'd0);
        check("midrst_mask", 32'(fmask), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_rst", 32'(busy), 32'd0);
        run_sweep(vecs[0], 5);

        // Settle-time variants, started together
        @(negedge clk);
        start0 = 1'b1;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start3 = 1'b0;
        lat0 = -1;
        lat3 = -1;
        k = 0;
        while (lat3 < 0 && k < 64) begin
            @(negedge clk);
            if (done0 && lat0 < 0) begin
                lat0 = k;
                check("s0_pass", 32'(pass0), 32'd1);
                check("s0_err", 32'(errc0), 32'd0);
            end
            if (done3 && lat3 < 0) begin
                lat3 = k;
                check("s3_pass", 32'(pass3), 32'd1);
                check("s3_mask", 32'(fmask3), 32'd0);
            end
            @(posedge clk);
            k++;
        end
        check("s0_latency", 32'(lat0), 32'd8);
        check("s3_latency", 32'(lat3), 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gate_sweep_ctrl

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Self-checking truth-table sequencer for a small combinational gate (NOR-class, N_IN inputs, 1 output).
- Drives every input combination to the gate in ascending order and waits a programmable settle time.
- Samples the gate output and compares it against a parameterised expected truth table.
- Accumulates errors and reports pass/fail. Sits beside the gate in a self-test top; replaces hand-written exhaustive benches.

Parameters:
- N_IN, 2, number of gate inputs; vectors swept = 2**N_IN.
- SETTLE_CYC, 1, cycles held between driving a vector and sampling; 0 allowed.
- EXPECTED, 4'b0001, expected truth table, width 2**N_IN; bit i = expected output for input value i (default = 2-input NOR).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin sweep; honoured only in IDLE.
- gate_out  input  1  output of the gate under control.
- gate_in  output  N_IN  registered vector driven to gate inputs, MSB = first gate input.
- busy  output  1  high from start acceptance until DONE is left.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  high when last completed sweep had err_count==0.
- err_count  output  N_IN+1  mismatches in current/last sweep.
- fail_mask  output  2**N_IN  bit i set if vector i mismatched.

Behaviour:
- Reset (rst high at edge): state=IDLE, gate_in=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, settle counter=0. Reset wins over every other event, including mid-sweep; no partial results kept.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1: clear err_count, fail_mask, pass; idx=0; gate_in=0; busy=1; go to DRIVE.
  - start=0: hold all outputs; results of the previous sweep stay visible.
- DRIVE: one cycle; load settle counter with SETTLE_CYC. Next state is SETTLE if SETTLE_CYC>0, else SAMPLE.
- SETTLE: decrement the counter each cycle; go to SAMPLE when it reaches 1 (exactly SETTLE_CYC cycles in SETTLE).
- SAMPLE: one cycle; compare gate_out with EXPECTED[idx].
  - On mismatch: err_count+1 and fail_mask[idx]=1.
  - If idx==2**N_IN-1, go to DONE. Otherwise idx+1, gate_in=idx+1, and go to DRIVE.
- DONE: one cycle with done=1; pass=(final err_count==0) is registered on DONE entry; busy=0 on exit. Then go to IDLE.
- Per-vector cost is 2+SETTLE_CYC cycles. done is high in the cycle after the (2**N_IN)*(2+SETTLE_CYC)-th edge following the start-accepting edge: 12 for defaults, 8 for SETTLE_CYC=0.
- gate_in changes only on DRIVE entry (and reset), never during SETTLE/SAMPLE.
- start while busy (DRIVE..DONE) is ignored, with no queuing. start held high continuously re-arms on the IDLE cycle after DONE.
- err_count cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- idx wrap-around is never reached; the sweep terminates on the last vector.

Decomposition:
- Package gate_sweep_pkg:
  - state enum typedef (IDLE, DRIVE, SETTLE, SAMPLE, DONE).
  - constant NOR2_TT = 4'b0001.
  - constants AND2_TT / OR2_TT for other gate benches.
- No sub-module inside the controller.
- Natural integration wrapper: nor_selftest_top, instantiating gate_sweep_ctrl plus NorGate, with gate_in[1]->a, gate_in[0]->b, out->gate_out.

Test Plan:
- Defaults with a correct NOR attached, pulse start: gate_in sequence 0,1,2,3; done 12 cycles later; pass=1, err_count=0, fail_mask=0000.
- gate_out stuck at 0: mismatch only at vector 0 -> err_count=1, fail_mask=0001, pass=0.
- gate_out stuck at 1: mismatches at 1,2,3 -> err_count=3, fail_mask=1110, pass=0. A following sweep with a correct gate clears to pass=1, err_count=0.
- start pulsed again at cycles 3 and 7 of a sweep: ignored, sweep finishes at cycle 12 with identical results; exactly one done pulse.
- rst asserted at cycle 5 of a sweep: next edge gives IDLE, gate_in=0, busy=0, done=0, err_count=0, fail_mask=0. A new start then completes normally.
- SETTLE_CYC=0 build, correct NOR: done 8 cycles after start, pass=1. SETTLE_CYC=3 build: done 20 cycles after start.
